// File: rtl/fsm_ctrl_ws_if.sv
// fsm_ctrl_ws_if: control bus between fsm_ctrl_ws (master: opcode/flags/handshake in, datapath controls and status out) and its datapath/memory (slave)
interface fsm_ctrl_ws_if #(
  parameter int STATE_W = 5,
  parameter int CNT_W = 16
);
  logic [3:0] instr;
  logic NOP, N, Z, mem_ready, resume;
  logic PCwrite, AddrSel, MemRead, MemWrite, IRload, R1Sel, MDRload, R1R2Load;
  logic ALU1, ALUOutWrite, RFWrite, RegIn, FlagWrite;
  logic [2:0] ALU2, ALUop;
  logic [STATE_W-1:0] ostate;
  logic halted;
  logic [1:0] err_code;
  logic [CNT_W-1:0] retired;
  modport master (
    input instr, NOP, N, Z, mem_ready, resume,
    output PCwrite, AddrSel, MemRead, MemWrite, IRload, R1Sel, MDRload, R1R2Load,
    output ALU1, ALUOutWrite, RFWrite, RegIn, FlagWrite, ALU2, ALUop,
    output ostate, halted, err_code, retired
  );
  modport slave (
    output instr, NOP, N, Z, mem_ready, resume,
    input PCwrite, AddrSel, MemRead, MemWrite, IRload, R1Sel, MDRload, R1R2Load,
    input ALU1, ALUOutWrite, RFWrite, RegIn, FlagWrite, ALU2, ALUop,
    input ostate, halted, err_code, retired
  );
endinterface

// File: rtl/fsm_ctrl_ws.sv
// fsm_ctrl_ws: multicycle CPU control FSM with memory wait timeout, halt/resume, sticky error code and retired-instruction counter; ports: clock, reset (async high), bus (fsm_ctrl_ws_if.master)
module fsm_ctrl_ws #(
  parameter int STATE_W = 5,
  parameter int TIMEOUT = 15,
  parameter int CNT_W = 16
) (
  input logic clock,
  input logic reset,
  fsm_ctrl_ws_if.master bus
);
  localparam int WAIT_W = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  typedef enum logic [4:0] {
    S_RESET = 5'd0, S_FETCH, S_DECODE, S_ASN, S_WB, S_SHIFT, S_ORI3, S_ORI4, S_ORI5,
    S_LD, S_LDWB, S_ST, S_BPZ, S_BZ, S_BNZ, S_HALT, S_ERR
  } state_t;
  state_t state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [1:0] err_q, err_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic mem_state, timed_out;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q <= S_RESET;
      wait_q <= '0;
      err_q <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q <= wait_d;
      err_q <= err_d;
      retired_q <= retired_d;
    end
  assign mem_state = state_q inside {S_FETCH, S_LD, S_ST};
  assign timed_out = (TIMEOUT != 0) && mem_state && !bus.mem_ready && (wait_q == WAIT_W'(TIMEOUT - 1));
  always_comb begin
    state_d = state_q;
    bus.PCwrite = 1'b0;
    bus.AddrSel = 1'b0;
    bus.MemRead = 1'b0;
    bus.MemWrite = 1'b0;
    bus.IRload = 1'b0;
    bus.R1Sel = 1'b0;
    bus.MDRload = 1'b0;
    bus.R1R2Load = 1'b0;
    bus.ALU1 = 1'b0;
    bus.ALUOutWrite = 1'b0;
    bus.RFWrite = 1'b0;
    bus.RegIn = 1'b0;
    bus.FlagWrite = 1'b0;
    bus.ALU2 = 3'b000;
    bus.ALUop = 3'b000;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        bus.AddrSel = 1'b1;
        bus.MemRead = 1'b1;
        bus.ALU2 = 3'b001;
        bus.PCwrite = bus.mem_ready;
        bus.IRload = bus.mem_ready;
        state_d = bus.mem_ready ? S_DECODE : timed_out ? S_ERR : S_FETCH;
      end
      S_DECODE: begin
        bus.R1R2Load = 1'b1;
        state_d = bus.instr inside {4'b0100, 4'b0110, 4'b1000} ? S_ASN
          : bus.instr[2:0] == 3'b011 ? S_SHIFT
          : bus.instr[2:0] == 3'b111 ? S_ORI3
          : bus.instr == 4'b0000 ? S_LD
          : bus.instr == 4'b0010 ? S_ST
          : bus.instr == 4'b1101 ? S_BPZ
          : bus.instr == 4'b0101 ? S_BZ
          : bus.instr == 4'b1001 ? S_BNZ
          : bus.instr == 4'b0001 ? (bus.NOP ? S_FETCH : S_HALT)
          : S_ERR;
      end
      S_ASN: begin
        bus.ALU1 = 1'b1;
        bus.ALUOutWrite = 1'b1;
        bus.FlagWrite = 1'b1;
        bus.ALUop = bus.instr == 4'b0110 ? 3'b001 : bus.instr == 4'b1000 ? 3'b011 : 3'b000;
        state_d = S_WB;
      end
      S_SHIFT: begin
        bus.ALU1 = 1'b1;
        bus.ALU2 = 3'b100;
        bus.ALUop = 3'b100;
        bus.ALUOutWrite = 1'b1;
        bus.FlagWrite = 1'b1;
        state_d = S_WB;
      end
      S_WB: begin
        bus.RFWrite = 1'b1;
        state_d = S_FETCH;
      end
      S_ORI3: begin
        bus.R1Sel = 1'b1;
        bus.R1R2Load = 1'b1;
        state_d = S_ORI4;
      end
      S_ORI4: begin
        bus.ALU1 = 1'b1;
        bus.ALU2 = 3'b011;
        bus.ALUop = 3'b010;
        bus.ALUOutWrite = 1'b1;
        bus.FlagWrite = 1'b1;
        state_d = S_ORI5;
      end
      S_ORI5: begin
        bus.R1Sel = 1'b1;
        bus.RFWrite = 1'b1;
        state_d = S_FETCH;
      end
      S_LD: begin
        bus.MemRead = 1'b1;
        bus.MDRload = bus.mem_ready;
        state_d = bus.mem_ready ? S_LDWB : timed_out ? S_ERR : S_LD;
      end
      S_LDWB: begin
        bus.ALUOutWrite = 1'b1;
        bus.RFWrite = 1'b1;
        bus.RegIn = 1'b1;
        state_d = S_FETCH;
      end
      S_ST: begin
        bus.MemWrite = 1'b1;
        state_d = bus.mem_ready ? S_FETCH : timed_out ? S_ERR : S_ST;
      end
      S_BPZ, S_BZ, S_BNZ: begin
        bus.ALU2 = 3'b010;
        bus.PCwrite = state_q == S_BPZ ? !bus.N : state_q == S_BZ ? bus.Z : !bus.Z;
        state_d = S_FETCH;
      end
      S_HALT: state_d = bus.resume ? S_FETCH : S_HALT;
      default: state_d = S_ERR;
    endcase
    // only DECODE can reach ERR through an opcode; every other entry is a memory timeout
    err_d = (state_d == S_ERR && state_q != S_ERR) ? (state_q == S_DECODE ? 2'b10 : 2'b01) : err_q;
    // any state change clears the count, so FETCH/LD/ST always start a fresh wait
    wait_d = state_d != state_q ? '0 : (mem_state && !bus.mem_ready && TIMEOUT != 0) ? wait_q + 1'b1 : wait_q;
    retired_d = (state_d == S_FETCH && !(state_q inside {S_RESET, S_FETCH, S_HALT})) ? retired_q + 1'b1 : retired_q;
  end
  assign bus.ostate = STATE_W'(state_q);
  assign bus.halted = state_q == S_HALT;
  assign bus.err_code = err_q;
  assign bus.retired = retired_q;
endmodule

// File: tb/tb_fsm_ctrl_ws.sv
// tb_fsm_ctrl_ws: randomized and steered stimulus for fsm_ctrl_ws checked every cycle against an instruction-path reference model
module tb_fsm_ctrl_ws;
  localparam int TIMEOUT = 15;
  localparam int CNT_W = 4;
  typedef struct packed {
    logic pcw, asel, mrd, mwr, irl, r1s, mdr, r12, alu1, aow, rfw, regin, fw;
    logic [2:0] alu2, aluop;
  } ctrl_t;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  int m_state = 0, m_wait = 0, m_err = 0, m_ret = 0;
  logic [3:0] ir = 4'h0;
  logic ir_nop = 1'b1;
  int rdy_pct = 100;
  int res_pct = 0;
  logic [4:0] prog[$];
  bit rdy_q[$];
  logic [3:0] legal[13] = '{4'h4, 4'h6, 4'h8, 4'h3, 4'hB, 4'h7, 4'hF, 4'h0, 4'h2, 4'hD, 4'h5, 4'h9, 4'h1};
  int pcts[4] = '{95, 70, 40, 15};
  fsm_ctrl_ws_if #(.STATE_W(5), .CNT_W(CNT_W)) bus ();
  fsm_ctrl_ws #(.STATE_W(5), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (.clock(clock), .reset(reset), .bus(bus.master));
  always #5 clock = ~clock;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic ctrl_t observed();
    ctrl_t c;
    c = {bus.PCwrite, bus.AddrSel, bus.MemRead, bus.MemWrite, bus.IRload, bus.R1Sel, bus.MDRload,
         bus.R1R2Load, bus.ALU1, bus.ALUOutWrite, bus.RFWrite, bus.RegIn, bus.FlagWrite, bus.ALU2, bus.ALUop};
    return c;
  endfunction
  function automatic int target(logic [3:0] i, logic nop);
    if (i == 4'b0100 || i == 4'b0110 || i == 4'b1000) return 3;
    if (i[2:0] == 3'b011) return 5;
    if (i[2:0] == 3'b111) return 6;
    if (i == 4'b0000) return 9;
    if (i == 4'b0010) return 11;
    if (i == 4'b1101) return 12;
    if (i == 4'b0101) return 13;
    if (i == 4'b1001) return 14;
    if (i == 4'b0001) return nop ? 1 : 15;
    return 16;
  endfunction
  function automatic ctrl_t exp_ctrl(int s, logic [3:0] i, logic n, logic z, logic r);
    ctrl_t c;
    c = '0;
    case (s)
      1: begin c.asel = 1; c.mrd = 1; c.alu2 = 3'b001; c.pcw = r; c.irl = r; end
      2: c.r12 = 1;
      3: begin c.alu1 = 1; c.aow = 1; c.fw = 1; c.aluop = i == 4'b0110 ? 3'b001 : i == 4'b1000 ? 3'b011 : 3'b000; end
      4: c.rfw = 1;
      5: begin c.alu1 = 1; c.alu2 = 3'b100; c.aluop = 3'b100; c.aow = 1; c.fw = 1; end
      6: begin c.r1s = 1; c.r12 = 1; end
      7: begin c.alu1 = 1; c.alu2 = 3'b011; c.aluop = 3'b010; c.aow = 1; c.fw = 1; end
      8: begin c.r1s = 1; c.rfw = 1; end
      9: begin c.mrd = 1; c.mdr = r; end
      10: begin c.aow = 1; c.rfw = 1; c.regin = 1; end
      11: c.mwr = 1;
      12: begin c.alu2 = 3'b010; c.pcw = !n; end
      13: begin c.alu2 = 3'b010; c.pcw = z; end
      14: begin c.alu2 = 3'b010; c.pcw = !z; end
      default: c = '0;
    endcase
    return c;
  endfunction
  task automatic load_ir();
    if (prog.size() > 0) {ir_nop, ir} = prog.pop_front();
    else begin
      ir = $urandom_range(9) == 0 ? 4'($urandom) : legal[$urandom_range(12)];
      ir_nop = $urandom_range(3) != 0;
    end
  endtask
  task automatic cycle();
    bit rdy;
    bit tmo;
    int nx;
    rdy = (m_state inside {1, 9, 11} && rdy_q.size() > 0) ? rdy_q.pop_front() : ($urandom_range(99) < rdy_pct);
    bus.mem_ready = rdy;
    bus.resume = $urandom_range(99) < res_pct;
    bus.N = 1'($urandom);
    bus.Z = 1'($urandom);
    bus.instr = ir;
    bus.NOP = ir_nop;
    #2;
    chk("ctrl", 32'(observed()), 32'(exp_ctrl(m_state, ir, bus.N, bus.Z, rdy)));
    chk("ostate", 32'(bus.ostate), m_state);
    chk("halted", 32'(bus.halted), 32'(m_state == 15));
    chk("err_code", 32'(bus.err_code), m_err);
    chk("retired", 32'(bus.retired), m_ret);
    tmo = !rdy && TIMEOUT != 0 && m_wait + 1 == TIMEOUT;
    case (m_state)
      0: nx = 1;
      1: nx = rdy ? 2 : tmo ? 16 : 1;
      2: nx = target(ir, ir_nop);
      3, 5: nx = 4;
      6: nx = 7;
      7: nx = 8;
      9: nx = rdy ? 10 : tmo ? 16 : 9;
      11: nx = rdy ? 1 : tmo ? 16 : 11;
      15: nx = bus.resume ? 1 : 15;
      16: nx = 16;
      default: nx = 1;
    endcase
    @(posedge clock);
    if (nx == 16 && m_state != 16) m_err = m_state == 2 ? 2 : 1;
    if (nx == 1 && m_state inside {2, 4, 8, 10, 11, 12, 13, 14}) m_ret = (m_ret + 1) % (1 << CNT_W);
    if (m_state == 1 && rdy) load_ir();
    m_wait = nx != m_state ? 0 : (m_state inside {1, 9, 11} && !rdy) ? m_wait + 1 : m_wait;
    m_state = nx;
    @(negedge clock);
  endtask
  task automatic run(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask
  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_ostate", 32'(bus.ostate), 0);
    chk("rst_ctrl", 32'(observed()), 0);
    chk("rst_err", 32'(bus.err_code), 0);
    chk("rst_retired", 32'(bus.retired), 0);
    chk("rst_halted", 32'(bus.halted), 0);
    m_state = 0;
    m_wait = 0;
    m_err = 0;
    m_ret = 0;
    prog.delete();
    rdy_q.delete();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask
  initial begin
    bus.instr = 4'h0;
    bus.NOP = 1'b1;
    bus.N = 1'b0;
    bus.Z = 1'b0;
    bus.mem_ready = 1'b0;
    bus.resume = 1'b0;
    do_reset();
    prog = '{5'h04, 5'h06, 5'h08, 5'h07, 5'h00, 5'h02, 5'h0D, 5'h09};
    run(31);
    chk("prog_retired", 32'(bus.retired), 8);
    do_reset();
    rdy_q = '{0, 0, 0, 1};
    run(8);
    do_reset();
    prog = '{5'h00};
    rdy_q.push_back(1);
    repeat (15) rdy_q.push_back(0);
    run(25);
    chk("ld_timeout_err", 32'(bus.err_code), 1);
    do_reset();
    prog = '{5'h00};
    rdy_q.push_back(1);
    repeat (14) rdy_q.push_back(0);
    rdy_q.push_back(1);
    run(20);
    chk("ld_late_ready_err", 32'(bus.err_code), 0);
    do_reset();
    prog = '{5'h01};
    run(14);
    chk("halt_held", 32'(bus.halted), 1);
    res_pct = 100;
    run(1);
    res_pct = 0;
    chk("resume_retired", 32'(bus.retired), 0);
    run(5);
    do_reset();
    prog = '{5'h03, 5'h0B, 5'h0A};
    run(20);
    chk("illegal_err", 32'(bus.err_code), 2);
    do_reset();
    repeat (16) prog.push_back(5'h11);
    run(33);
    chk("nop_wrap", 32'(bus.retired), 0);
    do_reset();
    prog = '{5'h02};
    rdy_q = '{1, 0, 0, 0, 0, 0};
    run(6);
    chk("st_wait_memwrite", 32'(bus.MemWrite), 1);
    #3;
    do_reset();
    res_pct = 30;
    for (int e = 0; e < 6; e++) begin
      rdy_pct = pcts[e % 4];
      if (e > 0) do_reset();
      run(300);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
